ysyx_idu: RTL and testbench

Instruction decode stage placed directly downstream of the fetch stage. Accepts one fetched 32-bit RV32I instruction and its PC per handshake and decodes it into register indices, a sign-extended immediate and control fields. Results are held in a registered output slot, with a one-entry skid buffer so the upstream `ready_o` never depends combinationally on `next_ready`. Supports a synchronous pipeline flush from branch/exception redirect.

---
 rtl/ysyx_idu.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ysyx_idu.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_idu.sv
// RV32I instruction decode stage with a registered output slot and a one-entry skid buffer.
// Define YSYX_IDU_RVE_EN for RV32E mode: register indices above x15 are reported illegal.
module ysyx_idu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_valid,
  output logic              ready_o,
  input  logic [DATA_W-1:0] inst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              valid_o,
  input  logic              next_ready,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [6:0]        opcode_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [4:0]        rd_o,
  output logic              wen_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              illegal_o
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

`ifdef YSYX_IDU_RVE_EN
  localparam bit RVE_EN = 1'b1;
`else
  localparam bit RVE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  state_e              state_q;
  logic                ready_q;
  logic                valid_q;
  logic [DATA_W-1:0]   skid_inst_q;
  logic [ADDR_W-1:0]   skid_pc_q;

  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   inst_q;
  logic [4:0]          rd_q;
  logic                wen_q;
  logic [DATA_W-1:0]   imm_q;
  logic                illegal_q;

  logic                accept_c;
  logic                consume_c;
  logic                load_c;

  logic [DATA_W-1:0]   src_inst;
  logic [ADDR_W-1:0]   src_pc;
  logic [6:0]          opc;
  logic [4:0]          f_rd;
  logic [4:0]          f_rs1;
  logic [4:0]          f_rs2;
  fmt_e                dec_fmt;
  logic                dec_legal;
  logic                dec_writes;
  logic                use_rs1;
  logic                use_rs2;
  logic                use_rd;
  logic                idx_bad;
  logic                dec_illegal;
  logic                dec_wen;
  logic [4:0]          dec_rd;
  logic [31:0]         imm32;
  logic [DATA_W-1:0]   dec_imm;

  assign accept_c  = prev_valid & ready_q & ~flush;
  assign consume_c = valid_q & next_ready;

  // The out slot is reloaded from the skid entry when draining SKID, else from the fetch input.
  assign load_c = ~flush & (((state_q == S_EMPTY) & accept_c) |
                            ((state_q == S_FULL) & consume_c & accept_c) |
                            ((state_q == S_SKID) & consume_c));

  assign src_inst = (state_q == S_SKID) ? skid_inst_q : inst;
  assign src_pc   = (state_q == S_SKID) ? skid_pc_q : pc;
  assign opc      = src_inst[6:0];
  assign f_rd     = src_inst[11:7];
  assign f_rs1    = src_inst[19:15];
  assign f_rs2    = src_inst[24:20];

  always_comb begin
    dec_fmt    = FMT_R;
    dec_legal  = 1'b1;
    dec_writes = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt    = FMT_U;
        dec_writes = 1'b1;
        use_rd     = 1'b1;
      end
      OPC_JAL: begin
        dec_fmt    = FMT_J;
        dec_writes = 1'b1;
        use_rd     = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
        dec_fmt    = FMT_I;
        dec_writes = 1'b1;
        use_rs1    = 1'b1;
        use_rd     = 1'b1;
      end
      OPC_MISC_MEM: begin
        dec_fmt = FMT_I;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OP: begin
        dec_fmt    = FMT_R;
        dec_writes = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        use_rd     = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Immediate assembly, wen and rd masking for the selected source word.
  always_comb begin
    idx_bad     = (use_rs1 & f_rs1[4]) | (use_rs2 & f_rs2[4]) | (use_rd & f_rd[4]);
    dec_illegal = ~dec_legal | (RVE_EN & idx_bad);
    imm32       = 32'd0;
    case (dec_fmt)
      FMT_I: imm32 = {{20{src_inst[31]}}, src_inst[31:20]};
      FMT_S: imm32 = {{20{src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
      FMT_B: imm32 = {{19{src_inst[31]}}, src_inst[31], src_inst[7], src_inst[30:25],
                      src_inst[11:8], 1'b0};
      FMT_U: imm32 = {src_inst[31:12], 12'd0};
      FMT_J: imm32 = {{11{src_inst[31]}}, src_inst[31], src_inst[19:12], src_inst[20],
                      src_inst[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
    if (dec_illegal) begin
      imm32 = 32'd0;
    end
    dec_imm = DATA_W'($signed(imm32));
    dec_wen = dec_writes & ~dec_illegal & (f_rd != 5'd0);
    dec_rd  = dec_wen ? f_rd : 5'd0;
  end

  // Slot/skid state machine; ready and valid are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
    end else if (flush) begin
      state_q     <= S_EMPTY;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept_c) begin
            state_q <= S_FULL;
            valid_q <= 1'b1;
          end
        end
        S_FULL: begin
          if (consume_c && !accept_c) begin
            state_q <= S_EMPTY;
            valid_q <= 1'b0;
          end else if (!consume_c && accept_c) begin
            state_q     <= S_SKID;
            ready_q     <= 1'b0;
            skid_inst_q <= inst;
            skid_pc_q   <= pc;
          end
        end
        S_SKID: begin
          if (consume_c) begin
            state_q <= S_FULL;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Output slot payload; holds whenever no load happens, so fields stay stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= '0;
      inst_q    <= '0;
      rd_q      <= 5'd0;
      wen_q     <= 1'b0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else if (load_c) begin
      pc_q      <= src_pc;
      inst_q    <= src_inst;
      rd_q      <= dec_rd;
      wen_q     <= dec_wen;
      imm_q     <= dec_imm;
      illegal_q <= dec_illegal;
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign pc_o      = pc_q;
  assign inst_o    = inst_q;
  assign opcode_o  = inst_q[6:0];
  assign funct3_o  = inst_q[14:12];
  assign funct7_o  = inst_q[31:25];
  assign rs1_o     = inst_q[19:15];
  assign rs2_o     = inst_q[24:20];
  assign rd_o      = rd_q;
  assign wen_o     = wen_q;
  assign imm_o     = imm_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_ysyx_idu.sv
// Bench for ysyx_idu: directed vector table, skid/flush/reset sequences, random traffic vs a queue model.
module tb_ysyx_idu;

  logic        clk = 1'b0;
  logic        rst;
  logic        prev_valid;
  logic        ready_o;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        flush;
  logic        valid_o;
  logic        next_ready;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  rd_o;
  logic        wen_o;
  logic [31:0] imm_o;
  logic        illegal_o;

  always #5 clk = ~clk;

  ysyx_idu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .prev_valid(prev_valid), .ready_o(ready_o),
    .inst(inst), .pc(pc), .flush(flush), .valid_o(valid_o), .next_ready(next_ready),
    .pc_o(pc_o), .inst_o(inst_o), .opcode_o(opcode_o), .funct3_o(funct3_o),
    .funct7_o(funct7_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .wen_o(wen_o),
    .imm_o(imm_o), .illegal_o(illegal_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } txn_t;

  typedef struct {
    logic        ill;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] imm;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        wen;
    logic        ill;
  } vec_t;

  txn_t mq[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference decode computed from the ISA field rules with shifts and masks.
  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    logic signed [31:0] sw;
    logic writes, legal, bad;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm;
    sw = w;
    rd = w[11:7];
    rs1 = w[19:15];
    rs2 = w[24:20];
    writes = 1'b0;
    legal = 1'b1;
    bad = 1'b0;
    imm = 32'd0;
    case (w[6:0])
      7'b0110111, 7'b0010111: begin
        writes = 1'b1; imm = w & 32'hFFFF_F000; bad = rd[4];
      end
      7'b1101111: begin
        writes = 1'b1; bad = rd[4];
        imm = 32'((sw >>> 31) <<< 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11)
              | (32'(w[30:21]) << 1);
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: begin
        writes = 1'b1; imm = 32'(sw >>> 20); bad = rd[4] | rs1[4];
      end
      7'b0001111: begin
        imm = 32'(sw >>> 20); bad = rd[4] | rs1[4];
      end
      7'b1100011: begin
        bad = rs1[4] | rs2[4];
        imm = 32'((sw >>> 31) <<< 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5)
              | (32'(w[11:8]) << 1);
      end
      7'b0100011: begin
        bad = rs1[4] | rs2[4];
        imm = 32'((sw >>> 25) <<< 5) | 32'(w[11:7]);
      end
      7'b0110011: begin
        writes = 1'b1; bad = rd[4] | rs1[4] | rs2[4];
      end
      default: legal = 1'b0;
    endcase
`ifndef YSYX_IDU_RVE_EN
    bad = 1'b0;
`endif
    e.ill = !legal || bad;
    e.imm = e.ill ? 32'd0 : imm;
    e.wen = writes && !e.ill && (rd != 5'd0);
    e.rd  = e.wen ? rd : 5'd0;
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    exp_t e;
    check({tag, ".valid"}, 32'(valid_o), 32'(mq.size() > 0));
    check({tag, ".ready"}, 32'(ready_o), 32'(mq.size() < 2));
    if (mq.size() > 0) begin
      e = ref_dec(mq[0].inst);
      check({tag, ".pc"}, pc_o, mq[0].pc);
      check({tag, ".inst"}, inst_o, mq[0].inst);
      check({tag, ".opcode"}, 32'(opcode_o), 32'(mq[0].inst[6:0]));
      check({tag, ".funct3"}, 32'(funct3_o), 32'(mq[0].inst[14:12]));
      check({tag, ".funct7"}, 32'(funct7_o), 32'(mq[0].inst[31:25]));
      check({tag, ".rs1"}, 32'(rs1_o), 32'(mq[0].inst[19:15]));
      check({tag, ".rs2"}, 32'(rs2_o), 32'(mq[0].inst[24:20]));
      check({tag, ".rd"}, 32'(rd_o), 32'(e.rd));
      check({tag, ".wen"}, 32'(wen_o), 32'(e.wen));
      check({tag, ".imm"}, imm_o, e.imm);
      check({tag, ".illegal"}, 32'(illegal_o), 32'(e.ill));
    end
  endtask

  // One clock: drive, advance the queue model by the pre-edge rules, compare after the edge.
  task automatic cycle(input string tag, input logic pv, input logic [31:0] i,
                       input logic [31:0] p, input logic fl, input logic nr);
    logic acc, con;
    prev_valid = pv;
    inst = i;
    pc = p;
    flush = fl;
    next_ready = nr;
    acc = pv && (mq.size() < 2) && !fl;
    con = (mq.size() > 0) && nr;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back('{i, p});
    end
    check_outputs(tag);
  endtask

  vec_t vecs[$];
  logic [6:0] ops[11];
  logic [31:0] ri;

  initial begin
    rst = 1'b1;
    prev_valid = 1'b0;
    inst = 32'd0;
    pc = 32'd0;
    flush = 1'b0;
    next_ready = 1'b0;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};

    vecs.push_back('{32'h0050_0093, 5'd1, 32'h0000_0005, 1'b1, 1'b0});
    vecs.push_back('{32'hFE00_0EE3, 5'd0, 32'hFFFF_FFFC, 1'b0, 1'b0});
    vecs.push_back('{32'h1234_52B7, 5'd5, 32'h1234_5000, 1'b1, 1'b0});
    vecs.push_back('{32'h0000_007F, 5'd0, 32'h0000_0000, 1'b0, 1'b1});
    vecs.push_back('{32'h0020_A423, 5'd0, 32'h0000_0008, 1'b0, 1'b0});
    vecs.push_back('{32'h0080_00EF, 5'd1, 32'h0000_0008, 1'b1, 1'b0});
    vecs.push_back('{32'h0020_81B3, 5'd3, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h0000_0013, 5'd0, 32'h0000_0000, 1'b0, 1'b0});
`ifdef YSYX_IDU_RVE_EN
    vecs.push_back('{32'h0010_0813, 5'd0, 32'h0000_0000, 1'b0, 1'b1});
`else
    vecs.push_back('{32'h0010_0813, 5'd16, 32'h0000_0001, 1'b1, 1'b0});
`endif

    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", 32'(valid_o), 32'd0);
    check("reset.ready", 32'(ready_o), 32'd1);
    check("reset.pc", pc_o, 32'd0);
    check("reset.inst", inst_o, 32'd0);
    check("reset.imm", imm_o, 32'd0);
    check("reset.rd", 32'(rd_o), 32'd0);
    rst = 1'b0;
    mq.delete();

    foreach (vecs[k]) begin
      cycle("vec", 1'b1, vecs[k].inst, 32'h8000_0000 + 32'(k * 4), 1'b0, 1'b1);
      check("vec.valid", 32'(valid_o), 32'd1);
      check("vec.rd", 32'(rd_o), 32'(vecs[k].rd));
      check("vec.imm", imm_o, vecs[k].imm);
      check("vec.wen", 32'(wen_o), 32'(vecs[k].wen));
      check("vec.illegal", 32'(illegal_o), 32'(vecs[k].ill));
      check("vec.pc", pc_o, 32'h8000_0000 + 32'(k * 4));
      cycle("drain", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    end

    // Backpressure into SKID, then drain in order.
    cycle("skid", 1'b1, 32'h0050_0093, 32'h0000_1000, 1'b0, 1'b0);
    cycle("skid", 1'b1, 32'h1234_52B7, 32'h0000_1004, 1'b0, 1'b0);
    check("skid.ready_low", 32'(ready_o), 32'd0);
    check("skid.first_pc", pc_o, 32'h0000_1000);
    cycle("skid", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("skid.hold_pc", pc_o, 32'h0000_1000);
    cycle("skid", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("skid.second_pc", pc_o, 32'h0000_1004);
    check("skid.second_rd", 32'(rd_o), 32'd5);
    check("skid.ready_back", 32'(ready_o), 32'd1);
    cycle("skid", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Flush while in SKID with a new instruction presented.
    cycle("flush", 1'b1, 32'h0050_0093, 32'h0000_2000, 1'b0, 1'b0);
    cycle("flush", 1'b1, 32'h0020_81B3, 32'h0000_2004, 1'b0, 1'b0);
    cycle("flush", 1'b1, 32'h1234_52B7, 32'h0000_2008, 1'b1, 1'b0);
    check("flush.valid", 32'(valid_o), 32'd0);
    check("flush.ready", 32'(ready_o), 32'd1);
    repeat (3) begin
      cycle("flush_after", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      check("flush.stays_empty", 32'(valid_o), 32'd0);
    end

    // Flush together with a consume from FULL.
    cycle("flcon", 1'b1, 32'h0050_0093, 32'h0000_3000, 1'b0, 1'b0);
    cycle("flcon", 1'b1, 32'h0050_0093, 32'h0000_3004, 1'b1, 1'b1);
    check("flcon.valid", 32'(valid_o), 32'd0);

    // Asynchronous reset while in SKID.
    cycle("rskid", 1'b1, 32'h0050_0093, 32'h0000_4000, 1'b0, 1'b0);
    cycle("rskid", 1'b1, 32'h0080_00EF, 32'h0000_4004, 1'b0, 1'b0);
    prev_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rskid.valid", 32'(valid_o), 32'd0);
    check("rskid.ready", 32'(ready_o), 32'd1);
    check("rskid.pc", pc_o, 32'd0);
    mq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle("rskid_after", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("rskid.after_valid", 32'(valid_o), 32'd0);

    for (int n = 0; n < 800; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 9) < 8) ri[6:0] = ops[$urandom_range(0, 10)];
      cycle("rand", ($urandom_range(0, 3) != 0), ri, $urandom,
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
